// File: rtl/melody_sequencer_if.sv
// rtl/melody_sequencer_if.sv - pattern table write port for melody_sequencer
interface melody_sequencer_if;
   logic       wr_en;
   logic [3:0] wr_addr;
   logic [7:0] wr_data;
   logic       wr_ready;

   modport master (output wr_en, wr_addr, wr_data, input wr_ready);
   modport slave  (input wr_en, wr_addr, wr_data, output wr_ready);
endinterface

// File: rtl/melody_sequencer.sv
// rtl/melody_sequencer.sv - 16-step note sequencer driving music feature enables
// Entry: [7:6] mode (00 base, 01 oct down, 10 oct up, 11 end), [5] tremolo, [4] led, [3:0] len.
module melody_sequencer #(
   parameter int BEAT_DIV   = 12000,
   parameter int GAP_CYCLES = 2
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start_i,
   input  logic               stop_i,
   input  logic               loop_i,
   melody_sequencer_if.slave  wr,
   output logic               tone_gate_o,
   output logic               octave_dena_o,
   output logic               octave_uena_o,
   output logic               tremolo_ena_o,
   output logic               led_ena_o,
   output logic [3:0]         step_idx_o,
   output logic               busy_o,
   output logic               done_o
);
   localparam int PW = (BEAT_DIV > 1) ? $clog2(BEAT_DIV) : 1;
   localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
   localparam logic [PW-1:0] PRESC_LAST = PW'(BEAT_DIV - 1);
   localparam logic [GW-1:0] GAP_LAST   = GW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
   localparam logic [1:0] MODE_DOWN = 2'b01;
   localparam logic [1:0] MODE_UP   = 2'b10;
   localparam logic [1:0] MODE_END  = 2'b11;

   typedef enum logic [1:0] {IDLE, PLAY, GAP} state_t;

   state_t        state_q, state_d;
   logic [7:0]    table_q [16];
   logic [3:0]    idx_q, idx_d;
   logic [PW-1:0] presc_q, presc_d;
   logic [3:0]    beat_q, beat_d;
   logic [GW-1:0] gap_q, gap_d;
   logic          gate_q, gate_d, dena_q, dena_d, uena_q, uena_d;
   logic          trem_q, trem_d, led_q, led_d, done_q, done_d;

   logic [3:0] cur_len, next_idx, load_idx;
   logic [1:0] load_mode;
   logic       load_trem, load_led;
   logic       note_end, gap_end, advance, has_next, start_ok, entry0_end, load;

   // Sequencing decisions are resolved here so the next-state block never feeds itself.
   assign cur_len    = table_q[idx_q][3:0];
   assign next_idx   = idx_q + 4'd1;
   assign entry0_end = (table_q[0][7:6] == MODE_END);
   assign note_end   = (state_q == PLAY) && (presc_q == PRESC_LAST) && (beat_q == cur_len);
   assign gap_end    = (state_q == GAP) && (gap_q == GAP_LAST);
   assign advance    = (note_end && (GAP_CYCLES == 0)) || gap_end;
   assign has_next   = (idx_q != 4'd15) && (table_q[next_idx][7:6] != MODE_END);
   assign start_ok   = (state_q == IDLE) && start_i && !stop_i;
   assign load_idx   = (advance && has_next) ? next_idx : 4'd0;
   assign load       = (start_ok && !entry0_end) || (advance && (has_next || loop_i));
   assign load_mode  = table_q[load_idx][7:6];
   assign load_trem  = table_q[load_idx][5];
   assign load_led   = table_q[load_idx][4];

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      presc_d = presc_q;
      beat_d  = beat_q;
      gap_d   = gap_q;
      gate_d  = gate_q;
      dena_d  = dena_q;
      uena_d  = uena_q;
      trem_d  = trem_q;
      led_d   = led_q;
      done_d  = 1'b0;

      case (state_q)
         IDLE: begin
            if (start_ok && entry0_end) done_d = 1'b1;
         end
         PLAY: begin
            if (presc_q == PRESC_LAST) begin
               presc_d = '0;
               if (beat_q == cur_len) begin
                  beat_d = 4'd0;
                  if (GAP_CYCLES != 0) begin
                     state_d = GAP;
                     gap_d   = '0;
                     gate_d  = 1'b0;
                     dena_d  = 1'b0;
                     uena_d  = 1'b0;
                     trem_d  = 1'b0;
                     led_d   = 1'b0;
                  end
               end else begin
                  beat_d = beat_q + 4'd1;
               end
            end else begin
               presc_d = presc_q + 1'b1;
            end
         end
         GAP: gap_d = gap_q + 1'b1;
         default: state_d = IDLE;
      endcase

      if (advance && !load) begin
         state_d = IDLE;
         idx_d   = 4'd0;
         gate_d  = 1'b0;
         dena_d  = 1'b0;
         uena_d  = 1'b0;
         trem_d  = 1'b0;
         led_d   = 1'b0;
         done_d  = 1'b1;
      end

      if (load) begin
         state_d = PLAY;
         idx_d   = load_idx;
         presc_d = '0;
         beat_d  = 4'd0;
         gap_d   = '0;
         gate_d  = 1'b1;
         dena_d  = (load_mode == MODE_DOWN);
         uena_d  = (load_mode == MODE_UP);
         trem_d  = load_trem;
         led_d   = load_led;
      end

      if (stop_i) begin
         state_d = IDLE;
         idx_d   = 4'd0;
         presc_d = '0;
         beat_d  = 4'd0;
         gap_d   = '0;
         gate_d  = 1'b0;
         dena_d  = 1'b0;
         uena_d  = 1'b0;
         trem_d  = 1'b0;
         led_d   = 1'b0;
         done_d  = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         idx_q   <= 4'd0;
         presc_q <= '0;
         beat_q  <= 4'd0;
         gap_q   <= '0;
         gate_q  <= 1'b0;
         dena_q  <= 1'b0;
         uena_q  <= 1'b0;
         trem_q  <= 1'b0;
         led_q   <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         presc_q <= presc_d;
         beat_q  <= beat_d;
         gap_q   <= gap_d;
         gate_q  <= gate_d;
         dena_q  <= dena_d;
         uena_q  <= uena_d;
         trem_q  <= trem_d;
         led_q   <= led_d;
         done_q  <= done_d;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < 16; i++) table_q[i] <= {MODE_END, 6'd0};
      end else if (wr.wr_en && (state_q == IDLE)) begin
         table_q[wr.wr_addr] <= wr.wr_data;
      end
   end

   assign wr.wr_ready    = (state_q == IDLE);
   assign busy_o         = (state_q != IDLE);
   assign tone_gate_o    = gate_q;
   assign octave_dena_o  = dena_q;
   assign octave_uena_o  = uena_q;
   assign tremolo_ena_o  = trem_q;
   assign led_ena_o      = led_q;
   assign step_idx_o     = idx_q;
   assign done_o         = done_q;
endmodule

// File: tb/tb_melody_sequencer.sv
// tb/tb_melody_sequencer.sv - self-checking bench for melody_sequencer
module tb_melody_sequencer;
   localparam int BEAT = 4;
   localparam int GAPC = 2;

   typedef struct packed {
      logic        wrap;
      logic [10:0] v;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic start_i = 1'b0, stop_i = 1'b0, loop_i = 1'b0;
   logic tone_gate_o, octave_dena_o, octave_uena_o, tremolo_ena_o, led_ena_o, busy_o, done_o;
   logic [3:0] step_idx_o;

   int checks = 0;
   int failures = 0;
   logic [7:0] tbl [16];
   exp_t exp_q[$];

   melody_sequencer_if wr_if ();

   melody_sequencer #(.BEAT_DIV(BEAT), .GAP_CYCLES(GAPC)) dut (
      .clk           (clk),
      .rst           (rst),
      .start_i       (start_i),
      .stop_i        (stop_i),
      .loop_i        (loop_i),
      .wr            (wr_if),
      .tone_gate_o   (tone_gate_o),
      .octave_dena_o (octave_dena_o),
      .octave_uena_o (octave_uena_o),
      .tremolo_ena_o (tremolo_ena_o),
      .led_ena_o     (led_ena_o),
      .step_idx_o    (step_idx_o),
      .busy_o        (busy_o),
      .done_o        (done_o)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // {gate, oct_down, oct_up, tremolo, led, busy, done, idx}
   function automatic logic [10:0] pk(input logic g, od, ou, tr, ld, bz, dn, input logic [3:0] ix);
      return {g, od, ou, tr, ld, bz, dn, ix};
   endfunction

   function automatic logic [10:0] dut_vec();
      return {tone_gate_o, octave_dena_o, octave_uena_o, tremolo_ena_o, led_ena_o,
              busy_o, done_o, step_idx_o};
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         failures++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
      end
   endtask

   // Expands the note table into the per-cycle output timeline, starting at cycle 1.
   task automatic build(input int nwraps);
      int idx, w, nlen;
      logic [7:0] e;
      logic wrapflag;
      exp_q = {};
      idx = 0; w = 0; wrapflag = 1'b0;
      if (tbl[0][7:6] == 2'b11) begin
         exp_q.push_back('{1'b0, pk(0, 0, 0, 0, 0, 0, 1, 4'd0)});
         return;
      end
      forever begin
         e = tbl[idx];
         nlen = (int'(e[3:0]) + 1) * BEAT;
         for (int k = 0; k < nlen; k++)
            exp_q.push_back('{(k == 0) && wrapflag,
                              pk(1, e[7:6] == 2'b01, e[7:6] == 2'b10, e[5], e[4], 1, 0, 4'(idx))});
         wrapflag = 1'b0;
         for (int k = 0; k < GAPC; k++)
            exp_q.push_back('{1'b0, pk(0, 0, 0, 0, 0, 1, 0, 4'(idx))});
         if (idx != 15 && tbl[idx+1][7:6] != 2'b11) begin
            idx++;
         end else if (w < nwraps) begin
            idx = 0; w++; wrapflag = 1'b1;
         end else begin
            break;
         end
      end
      exp_q.push_back('{1'b0, pk(0, 0, 0, 0, 0, 0, 1, 4'd0)});
   endtask

   task automatic wr(input logic [3:0] a, input logic [7:0] d);
      wr_if.wr_en = 1'b1; wr_if.wr_addr = a; wr_if.wr_data = d;
      tick();
      wr_if.wr_en = 1'b0;
      tbl[a] = d;
   endtask

   task automatic run(input string tag, input int nwraps, input int stop_at, input bit poke,
                      output int done_cyc);
      int wraps;
      build(nwraps);
      wraps = 0; done_cyc = -1;
      loop_i = (nwraps > 0);
      start_i = 1'b1;
      tick();
      start_i = 1'b0;
      for (int c = 1; c <= exp_q.size(); c++) begin
         wr_if.wr_en = 1'b0;
         start_i = 1'b0;
         if (exp_q[c-1].wrap) wraps++;
         loop_i = (wraps < nwraps);
         chk({tag, "_out"}, 32'(dut_vec()), 32'(exp_q[c-1].v));
         chk({tag, "_wr_ready"}, 32'(wr_if.wr_ready), 32'(!exp_q[c-1].v[5]));
         if (done_o && done_cyc < 0) done_cyc = c;
         if (c == stop_at) begin
            stop_i = 1'b1;
            tick();
            stop_i = 1'b0;
            loop_i = 1'b0;
            chk({tag, "_stopped"}, 32'(dut_vec()), 32'd0);
            return;
         end
         if (poke && c == 3) begin
            wr_if.wr_en = 1'b1; wr_if.wr_addr = 4'd0; wr_if.wr_data = 8'h2F;
            start_i = 1'b1;
         end
         tick();
      end
      wr_if.wr_en = 1'b0; start_i = 1'b0; loop_i = 1'b0;
      chk({tag, "_idle_after"}, 32'(dut_vec()), 32'd0);
   endtask

   initial begin
      int dc, len_pat, nw, sa;
      logic [7:0] d;
      wr_if.wr_en = 1'b0; wr_if.wr_addr = 4'd0; wr_if.wr_data = 8'd0;
      for (int i = 0; i < 16; i++) tbl[i] = 8'hC0;

      tick(); tick();
      rst = 1'b0;
      chk("reset_outs", 32'(dut_vec()), 32'd0);
      chk("reset_wr_ready", 32'(wr_if.wr_ready), 32'd1);

      run("empty", 0, 0, 1'b0, dc);
      chk("empty_done_cycle", dc, 1);

      wr(4'd0, 8'h41); wr(4'd1, 8'h90); wr(4'd2, 8'hC0);
      start_i = 1'b1; stop_i = 1'b1;
      tick();
      start_i = 1'b0; stop_i = 1'b0;
      chk("start_stop_idle", 32'(dut_vec()), 32'd0);

      run("oneshot", 0, 0, 1'b1, dc);
      chk("oneshot_done_cycle", dc, 17);
      run("loop", 1, 0, 1'b0, dc);
      run("stop", 0, 5, 1'b0, dc);
      run("replay", 0, 0, 1'b0, dc);
      chk("replay_done_cycle", dc, 17);

      for (int i = 0; i < 16; i++) wr(4'(i), 8'h20);
      run("full", 0, 0, 1'b0, dc);
      chk("full_done_cycle", dc, 97);

      for (int r = 0; r < 6; r++) begin
         len_pat = $urandom_range(1, 16);
         for (int i = 0; i < 16; i++) begin
            if (i < len_pat)
               d = {2'($urandom_range(0, 2)), 2'($urandom_range(0, 3)), 4'($urandom_range(0, 2))};
            else
               d = 8'($urandom);
            if (i == len_pat) d[7:6] = 2'b11;
            wr(4'(i), d);
         end
         nw = $urandom_range(0, 1);
         sa = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 30) : 0;
         run("rand", nw, sa, 1'b0, dc);
      end

      wr(4'd0, 8'h11); wr(4'd1, 8'hC0);
      loop_i = 1'b1;
      start_i = 1'b1;
      tick();
      start_i = 1'b0;
      for (int k = 0; k < 6; k++) tick();
      rst = 1'b1;
      tick();
      rst = 1'b0; loop_i = 1'b0;
      for (int i = 0; i < 16; i++) tbl[i] = 8'hC0;
      chk("midrst_outs", 32'(dut_vec()), 32'd0);
      chk("midrst_wr_ready", 32'(wr_if.wr_ready), 32'd1);
      run("post_rst", 0, 0, 1'b0, dc);
      chk("post_rst_done_cycle", dc, 1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
